// File: rtl/seg7_text_scroller.sv
// -----------------------------------------------------------------------------
// seg7_text_scroller
//  Multi-digit 7-segment text driver. Characters (6-bit codes) are appended to
//  a message buffer. A NUM_DIGITS-wide window of the message is shown on
//  parallel active-low segment outputs. Messages longer than the display
//  scroll circularly, one character every SCROLL_DIV clocks.
//
//  Optional feature macro: SEG7_SCROLL_BLINK_EN
//   When defined, this adds the blink_i port and the BLINK_DIV parameter.
//   While blink_i is high, the display alternates between ON and OFF (all
//   segments dark) every BLINK_DIV clocks.
//
//  Ports
//   clk_i        in   clock
//   rst_i        in   asynchronous active-high reset
//   wr_valid_i   in   append wr_char_i to the message
//   wr_char_i    in   6-bit character code
//   wr_ready_o   out  buffer can accept a write (combinational from clear_i)
//   clear_i      in   empty the message (wins over a same-cycle write)
//   scroll_en_i  in   enable scrolling
//   blink_i      in   blink the display (only with SEG7_SCROLL_BLINK_EN)
//   len_o        out  current message length
//   seg_o        out  per digit gfedcba, 0=ON; digit 0 (leftmost) in the MSBs
// -----------------------------------------------------------------------------
module seg7_text_scroller #(
   parameter int NUM_DIGITS = 4,
   parameter int DEPTH      = 16,
   parameter int SCROLL_DIV = 25_000_000
`ifdef SEG7_SCROLL_BLINK_EN
   ,
   parameter int BLINK_DIV  = 12_500_000
`endif
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_valid_i,
   input  logic [5:0]                   wr_char_i,
   output logic                         wr_ready_o,
   input  logic                         clear_i,
   input  logic                         scroll_en_i,
`ifdef SEG7_SCROLL_BLINK_EN
   input  logic                         blink_i,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   len_o,
   output logic [7*NUM_DIGITS-1:0]      seg_o
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = $clog2(SCROLL_DIV+1);
   localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV-1);
   localparam logic [LW-1:0] DEPTH_L     = LW'(DEPTH);
   localparam logic [LW-1:0] DIGITS_L    = LW'(NUM_DIGITS);
   localparam logic [5:0]    CODE_BLANK  = 6'd63;

   // Fixed character map, active-low gfedcba.
   function automatic logic [6:0] f_glyph(input logic [5:0] code);
      logic [6:0] g;
      g = 7'h7F;
      case (code)
         6'd0:  g = 7'h40;  6'd1:  g = 7'h79;  6'd2:  g = 7'h24;  6'd3:  g = 7'h30;
         6'd4:  g = 7'h19;  6'd5:  g = 7'h12;  6'd6:  g = 7'h02;  6'd7:  g = 7'h78;
         6'd8:  g = 7'h00;  6'd9:  g = 7'h10;  6'd10: g = 7'h08;  6'd11: g = 7'h03;
         6'd12: g = 7'h46;  6'd13: g = 7'h21;  6'd14: g = 7'h06;  6'd15: g = 7'h0E;
         6'd16: g = 7'h42;  6'd17: g = 7'h09;  6'd18: g = 7'h79;  6'd19: g = 7'h61;
         6'd20: g = 7'h0A;  6'd21: g = 7'h47;  6'd22: g = 7'h2A;  6'd23: g = 7'h2B;
         6'd24: g = 7'h40;  6'd25: g = 7'h0C;  6'd26: g = 7'h18;  6'd27: g = 7'h2F;
         6'd28: g = 7'h12;  6'd29: g = 7'h07;  6'd30: g = 7'h41;  6'd31: g = 7'h63;
         6'd32: g = 7'h55;  6'd33: g = 7'h09;  6'd34: g = 7'h11;  6'd35: g = 7'h24;
         6'd36: g = 7'h7F;  6'd37: g = 7'h3F;  6'd38: g = 7'h77;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   logic [5:0]              r_buf [DEPTH];
   logic [LW-1:0]           r_len;
   logic [LW-1:0]           r_offset;
   logic [SW-1:0]           r_scroll_cnt;
   logic [7*NUM_DIGITS-1:0] r_seg;
   logic                    r_live;     // low during reset and until the first edge after it

   logic                    w_wr_ready;
   logic                    w_wr_fire;
   logic                    w_scroll_active;
   logic                    w_blink_off_next;
   logic [7*NUM_DIGITS-1:0] w_window;

   assign w_wr_ready      = r_live && !clear_i && (r_len < DEPTH_L);
   assign w_wr_fire       = wr_valid_i && w_wr_ready;
   assign w_scroll_active = scroll_en_i && (r_len > DIGITS_L);

   assign wr_ready_o = w_wr_ready;
   assign len_o      = r_len;
   assign seg_o      = r_seg;

   // Message storage: no reset needed, len=0 masks stale contents.
   always_ff @(posedge clk_i) begin
      if (w_wr_fire) begin
         r_buf[r_len[IW-1:0]] <= wr_char_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_len        <= '0;
         r_offset     <= '0;
         r_scroll_cnt <= '0;
         r_live       <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (clear_i) begin
            r_len        <= '0;
            r_offset     <= '0;
            r_scroll_cnt <= '0;
         end else begin
            if (w_wr_fire) begin
               r_len <= r_len + LW'(1);
            end
            if (r_len <= DIGITS_L) begin
               r_offset <= '0;
            end else if (w_scroll_active) begin
               if (r_scroll_cnt == SCROLL_LAST) begin
                  r_scroll_cnt <= '0;
                  r_offset     <= (r_offset == r_len - LW'(1)) ? '0 : r_offset + LW'(1);
               end else begin
                  r_scroll_cnt <= r_scroll_cnt + SW'(1);
               end
            end
         end
      end
   end

`ifdef SEG7_SCROLL_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV+1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV-1);

   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_off;
   logic [BW-1:0] w_blink_cnt_next;

   always_comb begin
      w_blink_cnt_next = r_blink_cnt;
      w_blink_off_next = r_blink_off;
      if (!blink_i) begin
         w_blink_cnt_next = '0;
         w_blink_off_next = 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         w_blink_cnt_next = '0;
         w_blink_off_next = !r_blink_off;
      end else begin
         w_blink_cnt_next = r_blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end else begin
         r_blink_cnt <= w_blink_cnt_next;
         r_blink_off <= w_blink_off_next;
      end
   end
`else
   assign w_blink_off_next = 1'b0;
`endif

   // Window: one subtraction wraps offset+i because offset < len and i < len.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [LW:0]   w_sum;
         logic [LW:0]   w_wrap;
         logic [IW-1:0] w_idx;
         logic [5:0]    w_code;

         assign w_sum  = {1'b0, r_offset} + (LW+1)'(gi);
         assign w_wrap = (w_sum >= {1'b0, r_len}) ? w_sum - {1'b0, r_len} : w_sum;
         assign w_idx  = w_wrap[IW-1:0];

         always_comb begin
            w_code = CODE_BLANK;
            if (r_len <= DIGITS_L) begin
               if (LW'(gi) < r_len) begin
                  w_code = r_buf[gi];
               end
            end else begin
               w_code = r_buf[w_idx];
            end
         end

         assign w_window[7*(NUM_DIGITS-gi)-1 -: 7] = f_glyph(w_code);
      end
   endgenerate

   // Uses the next blink phase so that dropping blink_i restores the window
   // on the very next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_seg <= '1;
      end else begin
         r_seg <= w_blink_off_next ? '1 : w_window;
      end
   end

endmodule
